// File: rtl/overlay_pkg.sv
// Shared overlay definitions: lock FSM encoding, screen-centre constants and
// the frame-latched tracker record. The pixel mixer imports this too.
package overlay_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRACK   = 3'd1,
    ACQUIRE = 3'd2,
    LOCKED  = 3'd3,
    COAST   = 3'd4
  } lock_state_e;

  localparam int CX        = 320;
  localparam int CY        = 240;
  localparam int LOCK_ZONE = 30;

  typedef struct packed {
    logic [9:0]  aim_x;
    logic [9:0]  aim_y;
    logic [11:0] box_x_min;
    logic [11:0] box_x_max;
    logic [11:0] box_y_min;
    logic [11:0] box_y_max;
  } shadow_t;

  // Strict inequality on all four sides: the zone edges themselves are outside.
  function automatic logic in_zone(input logic [9:0] x, input logic [9:0] y,
                                   input int cx, input int cy, input int lz);
    return (int'(x) > cx - lz) && (int'(x) < cx + lz) &&
           (int'(y) > cy - lz) && (int'(y) < cy + lz);
  endfunction

endpackage

// File: rtl/overlay_lock_ctrl_if.sv
// Tracker-side inputs and mixer-side frame-latched outputs of the lock controller.
interface overlay_lock_ctrl_if;
  logic        frame_start;
  logic [9:0]  aim_x, aim_y;
  logic        aim_detected;
  logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;

  logic [9:0]  aim_x_q, aim_y_q;
  logic        aim_detected_q;
  logic [11:0] box_x_min_q, box_x_max_q, box_y_min_q, box_y_max_q;
  logic [2:0]  lock_state;
  logic        locked, lock_blink, lock_event, lock_lost;

  modport master (
    output frame_start, aim_x, aim_y, aim_detected,
           box_x_min, box_x_max, box_y_min, box_y_max,
    input  aim_x_q, aim_y_q, aim_detected_q,
           box_x_min_q, box_x_max_q, box_y_min_q, box_y_max_q,
           lock_state, locked, lock_blink, lock_event, lock_lost
  );

  modport slave (
    input  frame_start, aim_x, aim_y, aim_detected,
           box_x_min, box_x_max, box_y_min, box_y_max,
    output aim_x_q, aim_y_q, aim_detected_q,
           box_x_min_q, box_x_max_q, box_y_min_q, box_y_max_q,
           lock_state, locked, lock_blink, lock_event, lock_lost
  );
endinterface

// File: rtl/overlay_shadow_regs.sv
// Frame-latched tracker centroid/box; geometry holds its last valid value
// across frames where the tracker reports no detection.
module overlay_shadow_regs
  import overlay_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_frame_start,
  input  logic    i_det,
  input  shadow_t i_data,
  output shadow_t o_data,
  output logic    o_det
);

  shadow_t r_data;
  logic    r_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_det  <= 1'b0;
    end else if (i_frame_start) begin
      r_det <= i_det;
      if (i_det) r_data <= i_data;
    end
  end

  assign o_data = r_data;
  assign o_det  = r_det;

endmodule

// File: rtl/overlay_lock_ctrl.sv
// Frame-synchronous lock-on controller: double-buffers tracker geometry and runs
// the IDLE/TRACK/ACQUIRE/LOCKED/COAST lock FSM with blink and event pulses.
module overlay_lock_ctrl
  import overlay_pkg::*;
#(
  parameter int CX           = overlay_pkg::CX,
  parameter int CY           = overlay_pkg::CY,
  parameter int LOCK_ZONE    = overlay_pkg::LOCK_ZONE,
  parameter int LOCK_FRAMES  = 8,
  parameter int LOST_FRAMES  = 15,
  parameter int BLINK_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset,
  overlay_lock_ctrl_if.slave  bus
);

  lock_state_e r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt, r_bcnt, w_bcnt_nxt;
  logic        r_blink, w_blink_nxt;
  logic        r_event, r_lost, r_locked;
  logic        w_event_nxt, w_lost_nxt;
  logic        w_det, w_in_zone;
  shadow_t     w_shadow_in, w_shadow_q;
  logic        w_det_q;

  assign w_det     = bus.aim_detected;
  assign w_in_zone = in_zone(bus.aim_x, bus.aim_y, CX, CY, LOCK_ZONE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_blink_nxt = r_blink;
    w_event_nxt = 1'b0;
    w_lost_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_det && w_in_zone) begin
          w_state_nxt = ACQUIRE;
          w_cnt_nxt   = 8'd1;
        end else if (w_det) begin
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (!w_det) begin
          w_state_nxt = IDLE;
        end else if (w_in_zone) begin
          w_state_nxt = ACQUIRE;
          w_cnt_nxt   = 8'd1;
        end
      end
      ACQUIRE: begin
        if (!w_det) begin
          w_state_nxt = IDLE;
        end else if (!w_in_zone) begin
          w_state_nxt = TRACK;
        end else if (r_cnt == 8'(LOCK_FRAMES - 1)) begin
          w_state_nxt = LOCKED;
          w_event_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      LOCKED: begin
        if (w_det && !w_in_zone) begin
          w_state_nxt = TRACK;
          w_lost_nxt  = 1'b1;
        end else if (!w_det) begin
          w_state_nxt = COAST;
          w_cnt_nxt   = 8'd1;
          w_bcnt_nxt  = 8'd0;
        end
      end
      COAST: begin
        if (w_det && w_in_zone) begin
          w_state_nxt = LOCKED;
        end else if (w_det) begin
          w_state_nxt = TRACK;
          w_lost_nxt  = 1'b1;
        end else if (r_cnt == 8'(LOST_FRAMES - 1)) begin
          w_state_nxt = IDLE;
          w_lost_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          // The COAST entry frame is the first frame of the first blink half-period.
          if (r_bcnt == 8'(BLINK_FRAMES - 1)) begin
            w_bcnt_nxt  = 8'd0;
            w_blink_nxt = ~r_blink;
          end else begin
            w_bcnt_nxt = r_bcnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == LOCKED) begin
      w_blink_nxt = 1'b1;
    end else if (w_state_nxt != COAST || r_state != COAST) begin
      w_blink_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_bcnt   <= 8'd0;
      r_blink  <= 1'b0;
      r_event  <= 1'b0;
      r_lost   <= 1'b0;
      r_locked <= 1'b0;
    end else if (bus.frame_start) begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_blink  <= w_blink_nxt;
      r_event  <= w_event_nxt;
      r_lost   <= w_lost_nxt;
      r_locked <= (w_state_nxt == LOCKED) || (w_state_nxt == COAST);
    end else begin
      r_event <= 1'b0;
      r_lost  <= 1'b0;
    end
  end

  assign w_shadow_in = '{aim_x:     bus.aim_x,     aim_y:     bus.aim_y,
                         box_x_min: bus.box_x_min, box_x_max: bus.box_x_max,
                         box_y_min: bus.box_y_min, box_y_max: bus.box_y_max};

  overlay_shadow_regs u_shadow (
    .clk           (clk),
    .rst           (reset),
    .i_frame_start (bus.frame_start),
    .i_det         (w_det),
    .i_data        (w_shadow_in),
    .o_data        (w_shadow_q),
    .o_det         (w_det_q)
  );

  assign bus.aim_x_q        = w_shadow_q.aim_x;
  assign bus.aim_y_q        = w_shadow_q.aim_y;
  assign bus.box_x_min_q    = w_shadow_q.box_x_min;
  assign bus.box_x_max_q    = w_shadow_q.box_x_max;
  assign bus.box_y_min_q    = w_shadow_q.box_y_min;
  assign bus.box_y_max_q    = w_shadow_q.box_y_max;
  assign bus.aim_detected_q = w_det_q;
  assign bus.lock_state     = r_state;
  assign bus.locked         = r_locked;
  assign bus.lock_blink     = r_blink;
  assign bus.lock_event     = r_event;
  assign bus.lock_lost      = r_lost;

endmodule

// File: tb/tb_overlay_lock_ctrl.sv
// Table-driven frame vectors fed through a scoreboard queue, plus hand-written
// async-reset and no-frame_start sequences for overlay_lock_ctrl.
module tb_overlay_lock_ctrl;
  import overlay_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  overlay_lock_ctrl_if bus ();

  overlay_lock_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit         det;
    int         x, y;
    logic [2:0] st;
    bit         lk, bl, ev, lo;
    int         ax, ay;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   last_x = 0;
  int   last_y = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected geometry follows the last frame on which the tracker was valid.
  function automatic void add(input bit det, input int x, input int y, input logic [2:0] st,
                              input bit lk, input bit bl, input bit ev, input bit lo);
    vec_t v;
    if (det) begin
      last_x = x;
      last_y = y;
    end
    v.det = det; v.x = x; v.y = y; v.st = st;
    v.lk = lk; v.bl = bl; v.ev = ev; v.lo = lo;
    v.ax = last_x; v.ay = last_y;
    tbl.push_back(v);
  endfunction

  task automatic check_outputs(input vec_t e, input bit quiet);
    string t;
    t = quiet ? "quiet" : "frame";
    chk({t, " lock_state"}, int'(bus.lock_state), int'(e.st));
    chk({t, " locked"}, int'(bus.locked), int'(e.lk));
    chk({t, " lock_blink"}, int'(bus.lock_blink), int'(e.bl));
    chk({t, " lock_event"}, int'(bus.lock_event), quiet ? 0 : int'(e.ev));
    chk({t, " lock_lost"}, int'(bus.lock_lost), quiet ? 0 : int'(e.lo));
    chk({t, " aim_detected_q"}, int'(bus.aim_detected_q), int'(e.det));
    chk({t, " aim_x_q"}, int'(bus.aim_x_q), e.ax);
    chk({t, " aim_y_q"}, int'(bus.aim_y_q), e.ay);
    chk({t, " box_x_min_q"}, int'(bus.box_x_min_q), e.ax - 4);
    chk({t, " box_y_max_q"}, int'(bus.box_y_max_q), e.ay + 4);
  endtask

  task automatic drive_frame(input vec_t v);
    vec_t e;
    @(negedge clk);
    bus.aim_detected = v.det;
    bus.aim_x        = 10'(v.x);
    bus.aim_y        = 10'(v.y);
    bus.box_x_min    = 12'(v.x - 4);
    bus.box_x_max    = 12'(v.x + 4);
    bus.box_y_min    = 12'(v.y - 4);
    bus.box_y_max    = 12'(v.y + 4);
    bus.frame_start  = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: got empty queue, expected one entry");
      return;
    end
    e = sb.pop_front();
    check_outputs(e, 1'b0);
    // Between pulses the inputs are scrambled; nothing may move and pulses must drop.
    @(negedge clk);
    bus.frame_start  = 1'b0;
    bus.aim_detected = 1'($urandom);
    bus.aim_x        = 10'($urandom);
    bus.aim_y        = 10'($urandom);
    bus.box_x_min    = 12'($urandom);
    @(posedge clk);
    #1;
    check_outputs(e, 1'b1);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) drive_frame(tbl[i]);
    tbl.delete();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " lock_state"}, int'(bus.lock_state), 0);
    chk({name, " locked"}, int'(bus.locked), 0);
    chk({name, " lock_blink"}, int'(bus.lock_blink), 0);
    chk({name, " lock_event"}, int'(bus.lock_event), 0);
    chk({name, " lock_lost"}, int'(bus.lock_lost), 0);
    chk({name, " aim_detected_q"}, int'(bus.aim_detected_q), 0);
    chk({name, " aim_x_q"}, int'(bus.aim_x_q), 0);
    chk({name, " box_y_max_q"}, int'(bus.box_y_max_q), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary within time limit, expected completion");
    $fatal(1);
  end

  initial begin
    bus.frame_start = 1'b0; bus.aim_detected = 1'b0;
    bus.aim_x = '0; bus.aim_y = '0;
    bus.box_x_min = '0; bus.box_x_max = '0; bus.box_y_min = '0; bus.box_y_max = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) add(1, 100, 100, TRACK, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 320, 240, (i < 8) ? ACQUIRE : LOCKED, i == 8, i == 8, i == 8, 0);
    for (int k = 1; k <= 14; k++) add(0, 55, 77, COAST, 1, ((k - 1) / 4) % 2 == 1, 0, 0);
    add(1, 330, 250, LOCKED, 1, 1, 0, 0);
    for (int k = 1; k <= 15; k++)
      add(0, 11, 22, (k < 15) ? COAST : IDLE, k < 15,
          (k < 15) && (((k - 1) / 4) % 2 == 1), 0, k == 15);
    add(1, 290, 240, TRACK, 0, 0, 0, 0);
    add(1, 350, 240, TRACK, 0, 0, 0, 0);
    add(1, 291, 240, ACQUIRE, 0, 0, 0, 0);
    add(1, 349, 240, ACQUIRE, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 320, 240, ACQUIRE, 0, 0, 0, 0);
    add(1, 320, 270, TRACK, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 320, 269, (i < 8) ? ACQUIRE : LOCKED, i == 8, i == 8, i == 8, 0);
    add(1, 100, 100, TRACK, 0, 0, 0, 1);
    add(0, 0, 0, IDLE, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 320, 240, ACQUIRE, 0, 0, 0, 0);
    run_table();

    // Async reset between clock edges while ACQUIRE holds cnt=6.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    last_x = 0; last_y = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.aim_detected = 1'b1;
      bus.aim_x = 10'(320 + i);
      bus.aim_y = 10'd240;
      bus.box_y_max = 12'($urandom);
      @(posedge clk);
      #1 check_all_zero("no frame_start");
    end

    for (int i = 1; i <= 8; i++)
      add(1, 310, 260, (i < 8) ? ACQUIRE : LOCKED, i == 8, i == 8, i == 8, 0);
    add(0, 5, 5, COAST, 1, 0, 0, 0);
    add(1, 100, 100, TRACK, 0, 0, 0, 1);
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
